// File: rtl/alu_arbiter.sv
// Two requesters share one 8-bit ALU, with round-robin (FAIR=1) or req0-priority (FAIR=0) grant.
// An accept in cycle k gives a response from cycle k+2. The response holds under rsp backpressure, and only one op is in flight.
module alu_arbiter #(
  parameter int FAIR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_id,
  output logic       busy,
  output logic [7:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  logic       ptr;
  logic       grant1;
  logic       accept;
  logic [7:0] cap_a;
  logic [7:0] cap_b;
  logic [1:0] cap_op;
  logic       cap_id;
  logic [7:0] alu_result;

  // The pointer only decides a tie; a lone requester always wins.
  always_comb begin
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant1 = (FAIR != 0) ? ptr : 1'b0;
    end else begin
      grant1 = req1_valid;
    end
  end

  assign accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant1;
  assign req1_ready = accept && grant1;
  assign busy       = (state != IDLE);

  alu u_alu (
    .a      (cap_a),
    .b      (cap_b),
    .op     (cap_op),
    .result (alu_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      cap_a      <= 8'h00;
      cap_b      <= 8'h00;
      cap_op     <= 2'd0;
      cap_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= 8'h00;
      rsp_id     <= 1'b0;
      ops_done   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_a  <= grant1 ? req1_a  : req0_a;
            cap_b  <= grant1 ? req1_b  : req0_b;
            cap_op <= grant1 ? req1_op : req0_op;
            cap_id <= grant1;
            if (FAIR != 0) ptr <= ~grant1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_id     <= cap_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// Combinational 8-bit ALU with opcodes 0=ADD, 1=SUB, 2=AND, 3=OR. Results wrap modulo 256.
module alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] op,
  output logic [7:0] result
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;

  always_comb begin
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      default: result = a | b;
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. It drives one round-robin instance and one fixed-priority instance from shared requester inputs.
module tb_alu_arbiter;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;

  logic       a_req0_ready, a_req1_ready, a_rsp_valid, a_rsp_id, a_busy;
  logic [7:0] a_rsp_result, a_ops_done;
  logic       b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_busy;
  logic [7:0] b_rsp_result, b_ops_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  alu_arbiter #(.FAIR(1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(a_rsp_result), .rsp_id(a_rsp_id),
    .busy(a_busy), .ops_done(a_ops_done)
  );

  alu_arbiter #(.FAIR(0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(b_rsp_result), .rsp_id(b_rsp_id),
    .busy(b_busy), .ops_done(b_ops_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Reference model: one transaction at a time. The response is due two cycles after the accept.
  bit         m_busy[2];
  bit         m_ptr[2];
  bit         m_id[2];
  int         m_acc[2];
  int         m_cnt[2];
  logic [7:0] m_res[2];
  logic       o_r0[2], o_r1[2], o_rv[2], o_id[2], o_busy[2];
  logic [7:0] o_res[2], o_done[2];
  bit         g0, g1, erv;

  always @(negedge clk) begin
    o_r0[0] = a_req0_ready;  o_r0[1] = b_req0_ready;
    o_r1[0] = a_req1_ready;  o_r1[1] = b_req1_ready;
    o_rv[0] = a_rsp_valid;   o_rv[1] = b_rsp_valid;
    o_id[0] = a_rsp_id;      o_id[1] = b_rsp_id;
    o_busy[0] = a_busy;      o_busy[1] = b_busy;
    o_res[0] = a_rsp_result; o_res[1] = b_rsp_result;
    o_done[0] = a_ops_done;  o_done[1] = b_ops_done;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        chk($sformatf("d%0d_rst_req0_ready", d), o_r0[d], 0);
        chk($sformatf("d%0d_rst_req1_ready", d), o_r1[d], 0);
        chk($sformatf("d%0d_rst_rsp_valid", d), o_rv[d], 0);
        chk($sformatf("d%0d_rst_rsp_result", d), o_res[d], 0);
        chk($sformatf("d%0d_rst_rsp_id", d), o_id[d], 0);
        chk($sformatf("d%0d_rst_busy", d), o_busy[d], 0);
        chk($sformatf("d%0d_rst_ops_done", d), o_done[d], 0);
        m_busy[d] = 0; m_ptr[d] = 0; m_id[d] = 0; m_cnt[d] = 0; m_res[d] = 8'h00;
      end else begin
        g0 = 0; g1 = 0;
        if (!m_busy[d]) begin
          if (req0_valid && req1_valid) begin
            g1 = (d == 0) && m_ptr[d];
            g0 = !g1;
          end else begin
            g0 = req0_valid;
            g1 = req1_valid;
          end
        end
        erv = m_busy[d] && (cyc >= m_acc[d] + 2);
        chk($sformatf("d%0d_req0_ready", d), o_r0[d], g0);
        chk($sformatf("d%0d_req1_ready", d), o_r1[d], g1);
        chk($sformatf("d%0d_rsp_valid", d), o_rv[d], erv);
        chk($sformatf("d%0d_busy", d), o_busy[d], m_busy[d]);
        chk($sformatf("d%0d_ops_done", d), o_done[d], m_cnt[d] % 256);
        if (erv) begin
          chk($sformatf("d%0d_rsp_result", d), o_res[d], m_res[d]);
          chk($sformatf("d%0d_rsp_id", d), o_id[d], m_id[d]);
        end
        if (g0 || g1) begin
          m_busy[d] = 1;
          m_acc[d]  = cyc;
          m_id[d]   = g1;
          m_res[d]  = g1 ? alu_ref(req1_a, req1_b, req1_op) : alu_ref(req0_a, req0_b, req0_op);
          if (d == 0) m_ptr[d] = g0;
        end else if (erv && rsp_ready) begin
          m_busy[d] = 0;
          m_cnt[d]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic set_req(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] op0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] op1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
  endtask

  task automatic rand_inputs();
    req0_valid = ($urandom_range(0, 2) != 0);
    req1_valid = ($urandom_range(0, 2) != 0);
    req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
    req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 2'($urandom);
    rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int grants;
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_req(1, 8'd1, 8'd2, OP_ADD, 1, 8'd3, 8'd4, OP_SUB);
    repeat (2) @(posedge clk);
    look();
    chk("reset_req0_ready", a_req0_ready, 0);
    chk("reset_req1_ready", a_req1_ready, 0);
    chk("reset_rsp_valid", a_rsp_valid, 0);
    chk("reset_ops_done", a_ops_done, 0);
    step();
    rst = 1'b0;
    set_req(0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD);

    // req0 ADD 10+5 on its own
    step();
    set_req(1, 8'd10, 8'd5, OP_ADD, 0, 0, 0, OP_ADD);
    look(); chk("add_ready_k", a_req0_ready, 1);
    step(); req0_valid = 0;
    look(); chk("add_valid_k1", a_rsp_valid, 0); chk("add_busy_k1", a_busy, 1);
    step();
    look(); chk("add_valid_k2", a_rsp_valid, 1); chk("add_result", a_rsp_result, 8'd15); chk("add_id", a_rsp_id, 0);
    step();
    look(); chk("add_ops_done", a_ops_done, 1); chk("add_idle", a_busy, 0);

    // Both requesters arrive together straight after reset
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    set_req(1, 8'd100, 8'd40, OP_SUB, 1, 8'hCC, 8'hAA, OP_AND);
    look(); chk("rr_first_r0", a_req0_ready, 1); chk("rr_first_r1", a_req1_ready, 0);
    step(); req0_valid = 0;
    look(); chk("rr_wait_r1_k1", a_req1_ready, 0);
    step();
    look(); chk("rr_rsp1_result", a_rsp_result, 8'd60); chk("rr_rsp1_id", a_rsp_id, 0); chk("rr_wait_r1_k2", a_req1_ready, 0);
    step();
    look(); chk("rr_second_r1", a_req1_ready, 1);
    step(); req1_valid = 0;
    step();
    look(); chk("rr_rsp2_valid", a_rsp_valid, 1); chk("rr_rsp2_result", a_rsp_result, 8'h88); chk("rr_rsp2_id", a_rsp_id, 1);

    // Response held off for 5 cycles
    step();
    rsp_ready = 0;
    set_req(0, 0, 0, OP_ADD, 1, 8'hCC, 8'hAA, OP_OR);
    look(); chk("hold_accept", a_req1_ready, 1);
    step(); req1_valid = 0;
    look();
    for (int i = 0; i < 5; i++) begin
      step();
      set_req(1, 8'($urandom), 8'($urandom), 2'($urandom), 1, 8'($urandom), 8'($urandom), 2'($urandom));
      look();
      chk("hold_valid", a_rsp_valid, 1); chk("hold_result", a_rsp_result, 8'hEE); chk("hold_id", a_rsp_id, 1);
      chk("hold_busy", a_busy, 1); chk("hold_r0", a_req0_ready, 0); chk("hold_r1", a_req1_ready, 0);
    end
    step();
    rsp_ready = 1;
    set_req(0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD);
    look(); chk("hold_release_valid", a_rsp_valid, 1);
    step();
    look(); chk("hold_release_idle", a_busy, 0); chk("hold_release_done", a_ops_done, 3);

    // Fixed priority under continuous contention
    step();
    grants = 0;
    set_req(1, 8'd7, 8'd3, OP_SUB, 1, 8'd9, 8'd1, OP_ADD);
    for (int i = 0; i < 12; i++) begin
      look();
      chk("fp_req1_ready", b_req1_ready, 0);
      if (b_req0_ready) grants++;
      if (b_rsp_valid) chk("fp_rsp_id", b_rsp_id, 0);
      step();
    end
    set_req(0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD);
    chk("fp_grants", grants, 4);

    // Reset during EXEC of ADD 0+0
    step();
    set_req(1, 8'd0, 8'd0, OP_ADD, 0, 0, 0, OP_ADD);
    look(); chk("rexec_accept", a_req0_ready, 1);
    step(); req0_valid = 0;
    #2; rst = 1'b1; #1;
    chk("rexec_rsp_valid", a_rsp_valid, 0); chk("rexec_result", a_rsp_result, 0);
    chk("rexec_ops_done", a_ops_done, 0); chk("rexec_busy", a_busy, 0); chk("rexec_fp_ops_done", b_ops_done, 0);
    look();
    step(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      look(); chk("rexec_no_rsp", a_rsp_valid, 0); chk("rexec_done_zero", a_ops_done, 0);
      step();
    end

    // SUB 0-1 wraps, then run random traffic until 256 handshakes
    set_req(1, 8'd0, 8'd1, OP_SUB, 0, 0, 0, OP_ADD);
    rsp_ready = 1;
    look(); chk("sub_accept", a_req0_ready, 1);
    step(); req0_valid = 0;
    step();
    look(); chk("sub_valid", a_rsp_valid, 1); chk("sub_result", a_rsp_result, 8'hFF);
    step();
    for (int i = 0; i < 6000 && m_cnt[0] < 256; i++) begin
      rand_inputs();
      step();
    end
    set_req(0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD);
    chk("wrap_reached_256", m_cnt[0], 256);
    look(); chk("wrap_ops_done", a_ops_done, 8'h00);

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      step();
      rand_inputs();
      rst = ($urandom_range(0, 40) == 0);
    end
    step();
    rst = 1'b0;
    set_req(0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD);
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
